// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Largest supported RAM read latency; sizes the wait counter.
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (CPU, debug) plus the block-RAM side of the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          ram_ena;
  logic          ram_wea;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // Arbiter view.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_ena, ram_wea, ram_addr, ram_din,
    input  ram_dout
  );

  // Requester / RAM view.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_ena, ram_wea, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational picker: fixed CPU priority or alternate on a tie.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  // On a tie, favour the CPU unless round-robin says the CPU went last.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      if (fixed_prio || (last_gnt == PORT_DBG)) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU and the debug/loader port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_gnt;
  logic             cpu_rvalid_q;
  logic             dbg_rvalid_q;
  logic [DW-1:0]    cpu_rdata_q;
  logic [DW-1:0]    dbg_rdata_q;

  logic [1:0]       pick;
  logic [1:0]       grant;
  logic             win;
  logic             win_we;
  logic             any_gnt;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;

  rr_arb2 u_arb (
    .req        ({bus.dbg_req, bus.cpu_req}),
    .last_gnt   (last_gnt),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (pick)
  );

  // Issue only from IDLE and never while reset is held.
  always_comb begin
    grant     = 2'b00;
    if ((state == IDLE) && !reset) begin
      grant = pick;
    end
    any_gnt   = |grant;
    win       = grant[PORT_DBG];
    win_we    = win ? bus.dbg_we    : bus.cpu_we;
    win_addr  = win ? bus.dbg_addr  : bus.cpu_addr;
    win_wdata = win ? bus.dbg_wdata : bus.cpu_wdata;
  end

  assign bus.cpu_gnt    = grant[PORT_CPU];
  assign bus.dbg_gnt    = grant[PORT_DBG];
  assign bus.ram_ena    = any_gnt;
  assign bus.ram_wea    = any_gnt & win_we;
  assign bus.ram_addr   = win_addr;
  assign bus.ram_din    = win_wdata;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.cpu_stall  = bus.cpu_req & ~(grant[PORT_CPU] & bus.cpu_we) & ~cpu_rvalid_q;

  // Access sequencer: writes finish at grant, reads wait RD_LAT cycles then return data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= PORT_CPU;
      last_gnt     <= PORT_DBG;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_gnt) begin
            last_gnt <= win;
            if (!win_we) begin
              owner <= win;
              cnt   <= CNT_W'(RD_LAT);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            if (owner == PORT_DBG) begin
              dbg_rdata_q  <= bus.ram_dout;
              dbg_rvalid_q <= 1'b1;
            end else begin
              cpu_rdata_q  <= bus.ram_dout;
              cpu_rvalid_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
